// File: rtl/kbd_pkg.sv
// Shared types, control-byte constants and the PS/2 set-2 to Z88 matrix map
// used by the keyboard front end.
package kbd_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        DEC_BASE   = 2'd0,
        DEC_EXT    = 2'd1,
        DEC_BRK    = 2'd2,
        DEC_EXTBRK = 2'd3
    } dec_state_e;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_BAT    = 8'hAA;
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_ECHO   = 8'hEE;
    localparam logic [7:0] CODE_RESEND = 8'hFE;
    localparam logic [7:0] CODE_OVR0   = 8'h00;
    localparam logic [7:0] CODE_OVR1   = 8'hFF;

    // 1 when data plus parity bit hold an odd number of ones.
    function automatic logic odd_parity9(input logic [7:0] data, input logic par);
        return ^{par, data};
    endfunction

    // {ext, code} -> {valid, matrix index 8*row+col}
    function automatic logic [6:0] kbd_map(input logic [8:0] key);
        logic [6:0] res;
        case (key)
            9'h05A: res = {1'b1, 6'd6};   // Enter
            9'h029: res = {1'b1, 6'd61};  // Space
            9'h01C: res = {1'b1, 6'd53};  // A
            9'h012: res = {1'b1, 6'd62};  // left shift
            9'h059: res = {1'b1, 6'd63};  // right shift
            9'h066: res = {1'b1, 6'd7};   // backspace -> DEL
            9'h00D: res = {1'b1, 6'd60};  // Tab
            9'h076: res = {1'b1, 6'd59};  // Esc
            9'h175: res = {1'b1, 6'd27};  // Up
            9'h172: res = {1'b1, 6'd19};  // Down
            9'h16B: res = {1'b1, 6'd11};  // Left
            9'h174: res = {1'b1, 6'd3};   // Right
            9'h032: res = {1'b1, 6'd0};   // B
            9'h021: res = {1'b1, 6'd1};   // C
            9'h023: res = {1'b1, 6'd2};   // D
            9'h024: res = {1'b1, 6'd4};   // E
            9'h02B: res = {1'b1, 6'd5};   // F
            9'h034: res = {1'b1, 6'd8};   // G
            9'h033: res = {1'b1, 6'd9};   // H
            9'h043: res = {1'b1, 6'd10};  // I
            9'h03B: res = {1'b1, 6'd12};  // J
            9'h042: res = {1'b1, 6'd13};  // K
            9'h04B: res = {1'b1, 6'd14};  // L
            9'h03A: res = {1'b1, 6'd15};  // M
            9'h031: res = {1'b1, 6'd16};  // N
            9'h044: res = {1'b1, 6'd17};  // O
            9'h04D: res = {1'b1, 6'd18};  // P
            9'h015: res = {1'b1, 6'd20};  // Q
            9'h02D: res = {1'b1, 6'd21};  // R
            9'h01B: res = {1'b1, 6'd22};  // S
            9'h02C: res = {1'b1, 6'd23};  // T
            9'h03C: res = {1'b1, 6'd24};  // U
            9'h02A: res = {1'b1, 6'd25};  // V
            9'h01D: res = {1'b1, 6'd26};  // W
            9'h022: res = {1'b1, 6'd28};  // X
            9'h035: res = {1'b1, 6'd29};  // Y
            9'h01A: res = {1'b1, 6'd30};  // Z
            9'h016: res = {1'b1, 6'd31};  // 1
            9'h01E: res = {1'b1, 6'd32};  // 2
            9'h026: res = {1'b1, 6'd33};  // 3
            9'h025: res = {1'b1, 6'd34};  // 4
            9'h02E: res = {1'b1, 6'd35};  // 5
            9'h036: res = {1'b1, 6'd36};  // 6
            9'h03D: res = {1'b1, 6'd37};  // 7
            9'h03E: res = {1'b1, 6'd38};  // 8
            9'h046: res = {1'b1, 6'd39};  // 9
            9'h045: res = {1'b1, 6'd40};  // 0
            default: res = {1'b0, 6'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, start/data/
// parity/stop checking and an inactivity timeout that abandons partial frames.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT = 2048
) (
    input  logic       mck,
    input  logic       rin,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       rx_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);

    logic            clk_meta_r, clk_sync_r, clk_prev_r;
    logic            dat_meta_r, dat_sync_r;
    logic            fall_r, dat_r;
    rx_state_e       state_r, state_s;
    logic [2:0]      bit_cnt_r;
    logic [7:0]      shift_r;
    logic            par_ok_r;
    logic [CW-1:0]   idle_cnt_r;
    logic            vld_s, err_s;

    // Two-flop synchronisers and registered falling-edge detect (pins idle high)
    always_ff @(posedge mck) begin
        if (rin) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
            fall_r     <= 1'b0;
            dat_r      <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk;
            clk_sync_r <= clk_meta_r;
            clk_prev_r <= clk_sync_r;
            dat_meta_r <= ps2_dat;
            dat_sync_r <= dat_meta_r;
            fall_r     <= clk_prev_r & ~clk_sync_r;
            dat_r      <= dat_sync_r;
        end
    end

    // Receiver next state; a clock edge always wins over a coincident timeout
    always_comb begin
        state_s = state_r;
        vld_s   = 1'b0;
        err_s   = 1'b0;
        if (fall_r) begin
            case (state_r)
                RX_IDLE: begin
                    if (!dat_r) begin
                        state_s = RX_DATA;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt_r == 3'd7) begin
                        state_s = RX_PARITY;
                    end else begin
                        state_s = RX_DATA;
                    end
                end
                RX_PARITY: state_s = RX_STOP;
                RX_STOP: begin
                    state_s = RX_IDLE;
                    if (dat_r && par_ok_r) begin
                        vld_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: state_s = RX_IDLE;
            endcase
        end else if ((idle_cnt_r == TMO_MAX) && (state_r != RX_IDLE)) begin
            state_s = RX_IDLE;
            err_s   = 1'b1;
        end else begin
            state_s = state_r;
        end
    end

    // Receiver state, shift datapath, idle counter and registered outputs
    always_ff @(posedge mck) begin
        if (rin) begin
            state_r    <= RX_IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            par_ok_r   <= 1'b0;
            idle_cnt_r <= '0;
            byte_vld   <= 1'b0;
            byte_data  <= 8'd0;
            rx_err     <= 1'b0;
        end else begin
            state_r  <= state_s;
            byte_vld <= vld_s;
            rx_err   <= err_s;
            if (vld_s) begin
                byte_data <= shift_r;
            end
            if (fall_r) begin
                idle_cnt_r <= '0;
            end else if (idle_cnt_r != TMO_MAX) begin
                idle_cnt_r <= idle_cnt_r + 1'b1;
            end
            if (fall_r) begin
                case (state_r)
                    RX_IDLE:   bit_cnt_r <= 3'd0;
                    RX_DATA: begin
                        shift_r   <= {dat_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                    RX_PARITY: par_ok_r <= odd_parity9(shift_r, dat_r);
                    default:   par_ok_r <= par_ok_r;
                endcase
            end
        end
    end

endmodule

// File: rtl/kbd_matrix.sv
// PS/2 keyboard front end: decodes set-2 make/break sequences into the 64-bit
// Z88 key matrix read by the gate array.
module kbd_matrix
    import kbd_pkg::*;
#(
    parameter int TIMEOUT = 2048
) (
    input  logic        mck,
    input  logic        rin,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [63:0] kbmat,
    output logic        key_evt,
    output logic        rx_err
);

    logic       byte_vld;
    logic [7:0] byte_data;
    dec_state_e dec_r, dec_s;
    logic       apply_s, make_s, ext_s, clear_s;
    logic [6:0] map_s;
    logic       map_vld_s;
    logic [5:0] idx_s;
    logic       changed_s;

    ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .mck       (mck),
        .rin       (rin),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .byte_vld  (byte_vld),
        .byte_data (byte_data),
        .rx_err    (rx_err)
    );

    // Decoder next state and the make/break request for the received byte
    always_comb begin
        dec_s   = dec_r;
        apply_s = 1'b0;
        make_s  = 1'b0;
        ext_s   = 1'b0;
        clear_s = 1'b0;
        if (!byte_vld) begin
            dec_s = dec_r;
        end else if ((byte_data == CODE_BAT) || (byte_data == CODE_ACK) ||
                     (byte_data == CODE_ECHO) || (byte_data == CODE_RESEND)) begin
            dec_s = dec_r;
        end else if ((byte_data == CODE_OVR0) || (byte_data == CODE_OVR1)) begin
            clear_s = 1'b1;
            dec_s   = DEC_BASE;
        end else begin
            case (dec_r)
                DEC_BASE: begin
                    if (byte_data == CODE_EXT) begin
                        dec_s = DEC_EXT;
                    end else if (byte_data == CODE_BRK) begin
                        dec_s = DEC_BRK;
                    end else begin
                        apply_s = 1'b1;
                        make_s  = 1'b1;
                        dec_s   = DEC_BASE;
                    end
                end
                DEC_EXT: begin
                    if (byte_data == CODE_BRK) begin
                        dec_s = DEC_EXTBRK;
                    end else begin
                        apply_s = 1'b1;
                        make_s  = 1'b1;
                        ext_s   = 1'b1;
                        dec_s   = DEC_BASE;
                    end
                end
                DEC_BRK: begin
                    apply_s = 1'b1;
                    dec_s   = DEC_BASE;
                end
                DEC_EXTBRK: begin
                    apply_s = 1'b1;
                    ext_s   = 1'b1;
                    dec_s   = DEC_BASE;
                end
                default: dec_s = DEC_BASE;
            endcase
        end
    end

    assign map_s     = kbd_map({ext_s, byte_data});
    assign map_vld_s = map_s[6];
    assign idx_s     = map_s[5:0];
    // Typematic repeats leave the bit as it is, so they raise no event.
    assign changed_s = make_s ? ~kbmat[idx_s] : kbmat[idx_s];

    // Decoder state, key matrix and change pulse
    always_ff @(posedge mck) begin
        if (rin) begin
            dec_r   <= DEC_BASE;
            kbmat   <= 64'd0;
            key_evt <= 1'b0;
        end else begin
            dec_r <= dec_s;
            if (clear_s) begin
                kbmat   <= 64'd0;
                key_evt <= 1'b1;
            end else if (apply_s && map_vld_s && changed_s) begin
                kbmat[idx_s] <= make_s;
                key_evt      <= 1'b1;
            end else begin
                key_evt <= 1'b0;
            end
        end
    end

endmodule
